bsg_swap_router: RTL and testbench
==================================

// Module: bsg_swap_router
// PURPOSE
//  Two-lane 2x2 router. Sequences a bsg_swap datapath so that each input packet reaches
//  the output lane named by its dest bit. Resolves conflicts round-robin. Registers
//  outputs with a valid/yumi interface.
//  Sits between two producer channels and two consumer channels that share one swap unit.
// PARAMETERS
//  width_p      16  payload width per lane; swap bus is 2*width_p
//  cnt_width_p  8   conflict counter width (used only with the optional feature)
// PORTS
//  clk_i        in   1            clock
//  reset_i      in   1            synchronous, active-high reset
//  v_i          in   2            per-lane input valid
//  data_i       in   2*width_p    packed {lane1, lane0} payload
//  dest_i       in   2            per-lane destination output lane (0/1)
//  ready_o      out  2            per-lane accept; a transfer occurs when v_i[l] & ready_o[l]
//  v_o          out  2            per-lane output valid (registered)
//  data_o       out  2*width_p    packed {lane1, lane0} output payload (registered)
//  yumi_i       in   2            consumer takes output lane o this cycle; only legal when v_o[o]=1
//  conflict_cnt_o out cnt_width_p saturating conflict count (BSG_SWAP_ROUTER_CONFLICT_CNT_EN only)
// BEHAVIOUR
//  - Reset: v_o=2'b00, ready_o=2'b00, rr_ptr=0 (lane0 has priority), conflict_cnt_o=0.
//    A reset mid-operation drops any held outputs. data_o is don't-care while v_o=0.
//  - Output lane o is free when (!v_o[o] | yumi_i[o]). Same-cycle drain and refill give
//    full throughput.
//  - ready_o is combinational from v_i, dest_i, rr_ptr, v_o and yumi_i.
//    Latency from accept to v_o is 1 cycle.
//  - Grant rules, evaluated each cycle:
//    * one lane valid: grant if its target lane is free.
//    * both valid, different dests: grant each lane whose target is free, independently.
//    * both valid, same dest d (conflict): grant only lane rr_ptr, and only if d is free.
//      The loser holds; ready_o=0 for it.
//  - Swap select: swap = (granted lane index != its dest).
//    In the different-dest case: swap = dest_i[0].
//    No grant: swap is don't-care, and no output register loads.
//  - Output register o loads the swapped-bus half o when it is the target of a grant.
//    Otherwise, if yumi_i[o]=1, v_o[o] clears. Otherwise it holds.
//  - rr_ptr flips only on a cycle where a conflict grant actually occurs.
//    It holds on all other cycles, so the loser wins the next conflict (no starvation).
//  - Packets from one input lane to one output lane leave in order.
// CONFIGURATION
//  - Macro BSG_SWAP_ROUTER_CONFLICT_CNT_EN:
//    * defined: conflict_cnt_o exists. It increments by 1 on every cycle where both lanes
//      are valid with equal dest (granted or not), saturates at 2^cnt_width_p-1, and is
//      cleared by reset.
//    * undefined: the port and counter logic are absent. Routing behaviour is identical.
// STRUCTURE
//  - Package bsg_swap_router_pkg: lane index typedef (logic [0:0]), localparams
//    lane0_lp / lane1_lp, and a grant-case enum {e_idle, e_single, e_parallel, e_conflict}.
//  - One sub-module: the existing bsg_swap (width_p = 2*width_p), driven by the computed
//    swap select.
//  - Arbitration, rr_ptr, output registers and the counter live in this module.
// TESTING
//  1. Hold reset_i=1 with v_i=11 -> ready_o=00 and v_o=00 each cycle.
//     Release reset -> rr_ptr=0.
//  2. v_i=11, dest_i=2'b10, data_i={16'hAAAA,16'h5555}, yumi_i=11 -> ready_o=11.
//     Next cycle v_o=11, data_o={16'hAAAA,16'h5555}.
//  3. v_i=11, dest_i=2'b01, same data -> ready_o=11.
//     Next cycle data_o={16'h5555,16'hAAAA} (crossed).
//  4. Conflict: v_i=11, dest_i=2'b00, held 2 cycles, yumi_i[0]=1.
//     -> cycle0 ready_o=01, data_o[15:0]=lane0 data.
//     -> cycle1 ready_o=10, data_o[15:0]=lane1 data.
//     With the macro defined, conflict_cnt_o=2.
//  5. Backpressure: v_o[0]=1, yumi_i[0]=0, v_i=01, dest_i[0]=0 -> ready_o=00, output held.
//     Then yumi_i[0]=1 -> ready_o=01 in the same cycle, and v_o[0] stays 1 with new data.
//  6. Macro defined, cnt_width_p=2: 5 consecutive conflict cycles -> conflict_cnt_o
//     stays at 3. Reset -> 0.

Source files
------------

// File: rtl/bsg_swap_router_pkg.sv
// rtl/bsg_swap_router_pkg.sv - shared lane types and grant classification for bsg_swap_router
package bsg_swap_router_pkg;

    // One bit is enough to name either of the two lanes
    typedef logic [0:0] lane_t;

    localparam lane_t lane0_lp = 1'b0;
    localparam lane_t lane1_lp = 1'b1;

    // How the current cycle's input valids relate to each other
    typedef enum logic [1:0] {
        e_idle,
        e_single,
        e_parallel,
        e_conflict
    } grant_case_e;

endpackage

// File: rtl/bsg_swap.sv
// rtl/bsg_swap.sv - conditionally exchanges the two halves of a bus
module bsg_swap #(
    parameter int width_p = 32
) (
    input  logic [width_p-1:0] data_i,
    input  logic               swap_i,
    output logic [width_p-1:0] data_o
);

    localparam int half_lp = width_p / 2;

    // Straight through, or upper and lower halves exchanged
    always_comb begin
        data_o = data_i;
        if (swap_i) begin
            data_o = {data_i[half_lp-1:0], data_i[width_p-1:half_lp]};
        end
    end

endmodule

// File: rtl/bsg_swap_router.sv
// rtl/bsg_swap_router.sv - 2x2 round-robin router around one bsg_swap; optional counter via BSG_SWAP_ROUTER_CONFLICT_CNT_EN
module bsg_swap_router
    import bsg_swap_router_pkg::*;
#(
    parameter int width_p     = 16,
    parameter int cnt_width_p = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [1:0]           v_i,
    input  logic [2*width_p-1:0] data_i,
    input  logic [1:0]           dest_i,
    output logic [1:0]           ready_o,
    output logic [1:0]           v_o,
    output logic [2*width_p-1:0] data_o,
    input  logic [1:0]           yumi_i
`ifdef BSG_SWAP_ROUTER_CONFLICT_CNT_EN
    ,
    output logic [cnt_width_p-1:0] conflict_cnt_o
`endif
);

    lane_t                rr_ptr;
    grant_case_e          grant_case;
    lane_t                single_lane;
    logic [1:0]           free;
    logic [1:0]           grant;
    logic [1:0]           load;
    logic                 swap;
    logic                 conflict_grant;
    logic [2*width_p-1:0] swapped;

    // Classify the valid/dest pattern; a lone valid is lane1 only when v_i is 10
    always_comb begin
        grant_case  = e_idle;
        single_lane = v_i[1] ? lane1_lp : lane0_lp;
        if (v_i == 2'b11) begin
            grant_case = (dest_i[0] == dest_i[1]) ? e_conflict : e_parallel;
        end else if (v_i != 2'b00) begin
            grant_case = e_single;
        end
    end

    // Grant lanes whose target output can take a word this cycle and pick the swap
    always_comb begin
        free  = ~v_o | yumi_i;
        grant = 2'b00;
        swap  = 1'b0;
        case (grant_case)
            e_single: begin
                grant[single_lane] = free[dest_i[single_lane]];
                swap               = (single_lane != dest_i[single_lane]);
            end
            e_parallel: begin
                grant[0] = free[dest_i[0]];
                grant[1] = free[dest_i[1]];
                swap     = dest_i[0];
            end
            e_conflict: begin
                grant[rr_ptr] = free[dest_i[0]];
                swap          = (rr_ptr != dest_i[0]);
            end
            default: begin
                grant = 2'b00;
            end
        endcase
        if (reset_i) begin
            grant = 2'b00;
        end
    end

    // Output lane o loads whenever some granted input is headed for it
    always_comb begin
        load[0] = (grant[0] & ~dest_i[0]) | (grant[1] & ~dest_i[1]);
        load[1] = (grant[0] &  dest_i[0]) | (grant[1] &  dest_i[1]);
    end

    assign ready_o        = grant;
    assign conflict_grant = (grant_case == e_conflict) && (grant != 2'b00);

    bsg_swap #(
        .width_p (2*width_p)
    ) swap_unit (
        .data_i (data_i),
        .swap_i (swap),
        .data_o (swapped)
    );

    // Round-robin pointer moves only after a conflict is actually resolved
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr <= lane0_lp;
        end else if (conflict_grant) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    // Output registers: refill on load, drain on yumi, otherwise hold
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_o <= 2'b00;
        end else begin
            for (int o = 0; o < 2; o++) begin
                if (load[o]) begin
                    v_o[o]                       <= 1'b1;
                    data_o[o*width_p +: width_p] <= swapped[o*width_p +: width_p];
                end else if (yumi_i[o]) begin
                    v_o[o] <= 1'b0;
                end
            end
        end
    end

`ifdef BSG_SWAP_ROUTER_CONFLICT_CNT_EN
    // Count every cycle with both lanes contending for one output, saturating
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            conflict_cnt_o <= '0;
        end else if ((grant_case == e_conflict) && (conflict_cnt_o != '1)) begin
            conflict_cnt_o <= conflict_cnt_o + cnt_width_p'(1);
        end
    end
`else
    logic [cnt_width_p-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_bsg_swap_router.sv
// tb/tb_bsg_swap_router.sv - scoreboard bench for bsg_swap_router
module tb_bsg_swap_router;

    localparam int W = 16;
`ifdef BSG_SWAP_ROUTER_CONFLICT_CNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 8;
`endif

    logic           clk;
    logic           reset_i;
    logic [1:0]     v_i;
    logic [2*W-1:0] data_i;
    logic [1:0]     dest_i;
    logic [1:0]     ready_o;
    logic [1:0]     v_o;
    logic [2*W-1:0] data_o;
    logic [1:0]     yumi_i;
`ifdef BSG_SWAP_ROUTER_CONFLICT_CNT_EN
    logic [CW-1:0]  conflict_cnt_o;
`endif

    int passed = 0;
    int total  = 0;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];

    bsg_swap_router #(
        .width_p     (W),
        .cnt_width_p (CW)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .v_i            (v_i),
        .data_i         (data_i),
        .dest_i         (dest_i),
        .ready_o        (ready_o),
        .v_o            (v_o),
        .data_o         (data_o),
        .yumi_i         (yumi_i)
`ifdef BSG_SWAP_ROUTER_CONFLICT_CNT_EN
        ,
        .conflict_cnt_o (conflict_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every consumed output word is compared with the scoreboard head
    always @(negedge clk) begin
        if (!reset_i) begin
            for (int o = 0; o < 2; o++) begin
                if (v_o[o] && yumi_i[o]) begin
                    logic [W-1:0] got;
                    got = (o == 0) ? data_o[W-1:0] : data_o[2*W-1:W];
                    if (o == 0) begin
                        if (q0.size() == 0) check("out0_unexpected", 32'(got), 32'hFFFF_FFFF);
                        else check("out0_data", 32'(got), 32'(q0.pop_front()));
                    end else begin
                        if (q1.size() == 0) check("out1_unexpected", 32'(got), 32'hFFFF_FFFF);
                        else check("out1_data", 32'(got), 32'(q1.pop_front()));
                    end
                end
            end
        end
    end

    // Drive one cycle of inputs, check ready_o, and record where accepted words must appear
    task automatic step(input logic [1:0] v, input logic [1:0] d, input logic [31:0] dat,
                        input logic [1:0] y, input logic [1:0] exp_ready, input string name);
        @(posedge clk);
        #1;
        v_i    = v;
        dest_i = d;
        data_i = dat;
        yumi_i = y;
        @(negedge clk);
        check(name, 32'(ready_o), 32'(exp_ready));
        for (int l = 0; l < 2; l++) begin
            if (exp_ready[l]) begin
                if (d[l]) q1.push_back(dat[l*W +: W]);
                else      q0.push_back(dat[l*W +: W]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_i = 1'b1;
        v_i     = 2'b11;
        dest_i  = 2'b10;
        data_i  = '0;
        yumi_i  = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_ready", 32'(ready_o), 32'h0);
            check("reset_v_o", 32'(v_o), 32'h0);
        end
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        v_i     = 2'b00;

        step(2'b11, 2'b10, {16'hAAAA, 16'h5555}, 2'b11, 2'b11, "straight_ready");
        step(2'b11, 2'b01, {16'hAAAA, 16'h5555}, 2'b11, 2'b11, "crossed_ready");
        step(2'b11, 2'b00, {16'hBBBB, 16'hCCCC}, 2'b11, 2'b01, "conflict_c0_ready");
        step(2'b11, 2'b00, {16'hBBBB, 16'hCCCC}, 2'b01, 2'b10, "conflict_c1_ready");

        step(2'b01, 2'b00, {16'h0000, 16'hDDDD}, 2'b00, 2'b00, "bp_stall_ready");
`ifdef BSG_SWAP_ROUTER_CONFLICT_CNT_EN
        check("cnt_after_two", 32'(conflict_cnt_o), 32'd2);
`endif
        step(2'b01, 2'b00, {16'h0000, 16'hDDDD}, 2'b00, 2'b00, "bp_hold_ready");
        check("bp_hold_v_o", 32'(v_o), 32'h1);
        step(2'b01, 2'b00, {16'h0000, 16'hDDDD}, 2'b01, 2'b01, "bp_refill_ready");
        step(2'b00, 2'b00, 32'h0, 2'b01, 2'b00, "drain_ready");
        step(2'b00, 2'b00, 32'h0, 2'b00, 2'b00, "idle_ready");
        check("idle_v_o", 32'(v_o), 32'h0);

        step(2'b10, 2'b10, {16'hEEEE, 16'h0000}, 2'b00, 2'b10, "single_lane1_ready");
        step(2'b11, 2'b10, {16'hF1F1, 16'hF0F0}, 2'b00, 2'b01, "parallel_partial_ready");
        step(2'b00, 2'b00, 32'h0, 2'b11, 2'b00, "drain2_ready");
        step(2'b11, 2'b11, {16'hA1A1, 16'hA0A0}, 2'b00, 2'b01, "conflict_d1_ready");
        step(2'b11, 2'b11, {16'hA1A1, 16'hA0A0}, 2'b00, 2'b00, "conflict_busy_ready");
        step(2'b11, 2'b11, {16'hA1A1, 16'hA0A0}, 2'b10, 2'b10, "conflict_loser_ready");
        step(2'b00, 2'b00, 32'h0, 2'b10, 2'b00, "drain3_ready");
`ifdef BSG_SWAP_ROUTER_CONFLICT_CNT_EN
        check("cnt_saturated", 32'(conflict_cnt_o), 32'd3);
`endif

        step(2'b01, 2'b00, {16'h0000, 16'h1234}, 2'b00, 2'b01, "preload_ready");
        @(posedge clk);
        #1;
        v_i     = 2'b00;
        reset_i = 1'b1;
        @(negedge clk);
        check("held_before_reset", 32'(v_o), 32'h1);
        @(negedge clk);
        check("midreset_v_o", 32'(v_o), 32'h0);
`ifdef BSG_SWAP_ROUTER_CONFLICT_CNT_EN
        check("cnt_reset", 32'(conflict_cnt_o), 32'd0);
`endif
        q0.delete();
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);

        check("q0_empty", 32'(q0.size()), 32'd0);
        check("q1_empty", 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
